bus_arbiter: RTL

- Two-master arbiter in front of the CPU-side port of the Bridge.
- M0 is the CPU data port (Bus_addr/Bus_wen/Bus_wdata/Bus_rdata). M1 is a second data master, such as a UART program loader or DMA engine.
- Shares the single Bridge bus, and therefore DRAM and the dig/led/sw/btn peripherals, between the two masters.
- Fair round-robin arbitration, bounded burst length and lock for atomic sequences.

---
 rtl/bus_arbiter_pkg.sv | 17 +
 rtl/bus_arbiter_rr_pick.sv | 21 ++
 rtl/bus_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter:
// FSM state encodings, owner codes and the default burst limit.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_GNT0 = 2'b01,
        ARB_GNT1 = 2'b10
    } arb_state_t;

    localparam logic [1:0] OWN_IDLE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;

    localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational 2-way round-robin selector.
// pick=0 selects M0, pick=1 selects M1; a tie goes to the master != last.
module arb_rr_pick (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_pick,
    output logic o_valid
);

    // Tie-break against the previous owner, otherwise take the lone requester
    always_comb begin
        o_valid = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            o_pick = ~i_last;
        end else begin
            o_pick = i_req1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of the Bridge CPU-side port.
// Single-cycle bus: grant costs one IDLE cycle, then zero-latency beats.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int AW        = 32,
    parameter int DW        = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic          m0_wen,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
    input  logic          m1_req,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic          m1_wen,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
    output logic [AW-1:0] bus_addr,
    output logic          bus_wen,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    output logic [1:0]    owner
);

    localparam logic [3:0] LP_CNT_MAX = 4'(MAX_BURST - 1);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic [3:0] r_beat_cnt;
    logic [3:0] w_cnt_nxt;
    logic       r_last;
    logic       w_last_nxt;
    logic       w_pick;
    logic       w_valid;
    logic       w_own0;
    logic       w_own1;

    arb_rr_pick u_pick (
        .i_req0  (m0_req),
        .i_req1  (m1_req),
        .i_last  (r_last),
        .o_pick  (w_pick),
        .o_valid (w_valid)
    );

    // State, beat counter and last-owner registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_beat_cnt <= 4'd0;
            r_last     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_cnt_nxt;
            r_last     <= w_last_nxt;
        end
    end

    // Next-state: arbitration, burst limit, lock and early release
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_beat_cnt;
        w_last_nxt  = r_last;
        unique case (r_state)
            ARB_GNT0: begin
                if (m0_req) begin
                    if (m1_req && !m0_lock && r_beat_cnt == LP_CNT_MAX) begin
                        w_state_nxt = ARB_GNT1;
                        w_cnt_nxt   = 4'd0;
                        w_last_nxt  = 1'b0;
                    end else if (r_beat_cnt != LP_CNT_MAX) begin
                        w_cnt_nxt = r_beat_cnt + 4'd1;
                    end
                end else begin
                    w_state_nxt = m1_req ? ARB_GNT1 : ARB_IDLE;
                    w_cnt_nxt   = 4'd0;
                    w_last_nxt  = 1'b0;
                end
            end
            ARB_GNT1: begin
                if (m1_req) begin
                    if (m0_req && !m1_lock && r_beat_cnt == LP_CNT_MAX) begin
                        w_state_nxt = ARB_GNT0;
                        w_cnt_nxt   = 4'd0;
                        w_last_nxt  = 1'b1;
                    end else if (r_beat_cnt != LP_CNT_MAX) begin
                        w_cnt_nxt = r_beat_cnt + 4'd1;
                    end
                end else begin
                    w_state_nxt = m0_req ? ARB_GNT0 : ARB_IDLE;
                    w_cnt_nxt   = 4'd0;
                    w_last_nxt  = 1'b1;
                end
            end
            default: begin
                w_cnt_nxt = 4'd0;
                if (w_valid) begin
                    w_state_nxt = w_pick ? ARB_GNT1 : ARB_GNT0;
                end
            end
        endcase
    end

    // Datapath mux; reset forces every output idle so no write escapes
    always_comb begin
        w_own0    = !rst && r_state == ARB_GNT0 && m0_req;
        w_own1    = !rst && r_state == ARB_GNT1 && m1_req;
        bus_addr  = '0;
        bus_wen   = 1'b0;
        bus_wdata = '0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        m0_ack    = w_own0;
        m1_ack    = w_own1;
        if (w_own0) begin
            bus_addr  = m0_addr;
            bus_wen   = m0_wen;
            bus_wdata = m0_wdata;
            m0_rdata  = bus_rdata;
        end else if (w_own1) begin
            bus_addr  = m1_addr;
            bus_wen   = m1_wen;
            bus_wdata = m1_wdata;
            m1_rdata  = bus_rdata;
        end
    end

    // Owner code straight from the registered state
    always_comb begin
        owner = OWN_IDLE;
        if (!rst) begin
            unique case (r_state)
                ARB_GNT0: owner = OWN_M0;
                ARB_GNT1: owner = OWN_M1;
                default:  owner = OWN_IDLE;
            endcase
        end
    end

endmodule
